// File: rtl/nx_ram_hw_port_client_if.sv
// Bundle for the engine-facing request/response handshake and the RAM hw port.
// slave: the client block. master: the environment (engine plus RAM wrapper).
interface nx_ram_hw_port_client_if #(
  parameter int N_DATA_BITS = 32,
  parameter int ADDR_W      = 10
);
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_we;
  logic [ADDR_W-1:0]      req_addr;
  logic [N_DATA_BITS-1:0] req_bwe;
  logic [N_DATA_BITS-1:0] req_wdat;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [N_DATA_BITS-1:0] rsp_dat;
  logic [ADDR_W-1:0]      hw_add;
  logic                   hw_we;
  logic [N_DATA_BITS-1:0] hw_bwe;
  logic                   hw_cs;
  logic [N_DATA_BITS-1:0] hw_din;
  logic [N_DATA_BITS-1:0] hw_dout;
  logic                   hw_yield;

  modport master (
    output req_valid, req_we, req_addr, req_bwe, req_wdat, rsp_ready, hw_dout, hw_yield,
    input  req_ready, rsp_valid, rsp_dat, hw_add, hw_we, hw_bwe, hw_cs, hw_din
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_bwe, req_wdat, rsp_ready, hw_dout, hw_yield,
    output req_ready, rsp_valid, rsp_dat, hw_add, hw_we, hw_bwe, hw_cs, hw_din
  );
endinterface

// File: rtl/nx_ram_hw_port_client.sv
// Request adapter for one hw port of the 2-port indirect-access RAM wrapper.
// Requests queue in a small FIFO and issue to the RAM when the wrapper is not
// yielding; reads are credit-limited so returning data always fits the
// response FIFO, which hands data back in issue order.
module nx_ram_hw_port_client #(
  parameter int N_DATA_BITS   = 32,
  parameter int N_ENTRIES     = 1024,
  parameter int TOTAL_LATENCY = 1,
  parameter int REQ_DEPTH     = 2,
  parameter int RSP_DEPTH     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  nx_ram_hw_port_client_if.slave bus,
  output logic                   idle,
  output logic                   oor_err,
  output logic [15:0]            yield_cnt
);
  localparam int ADDR_W = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
  localparam int REQ_PW = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
  localparam int REQ_CW = $clog2(REQ_DEPTH + 1);
  localparam int RSP_PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int RSP_CW = $clog2(RSP_DEPTH + 1);
  localparam int CRD_W  = $clog2(TOTAL_LATENCY + RSP_DEPTH + 1) + 1;
  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(N_ENTRIES);

  typedef struct packed {
    logic                   we;
    logic [ADDR_W-1:0]      addr;
    logic [N_DATA_BITS-1:0] bwe;
    logic [N_DATA_BITS-1:0] wdat;
  } req_t;

  // request FIFO
  req_t                   req_mem [REQ_DEPTH];
  logic [REQ_PW-1:0]      req_wp, req_rp;
  logic [REQ_CW-1:0]      req_cnt;
  logic                   req_push, req_pop, head_valid, head_oor;
  req_t                   head;
  // issue / credit
  logic [CRD_W-1:0]       inflight, credit_used;
  logic                   credit_ok, issue, rd_issue;
  // in-flight read pipeline, stage i holds a read issued i cycles ago
  logic [TOTAL_LATENCY:1] vld_pipe, oor_pipe;
  // response FIFO
  logic [N_DATA_BITS-1:0] rsp_mem [RSP_DEPTH];
  logic [RSP_PW-1:0]      rsp_wp, rsp_rp;
  logic [RSP_CW-1:0]      rsp_cnt;
  logic                   rsp_push, rsp_pop, rsp_full, rsp_empty;
  logic [N_DATA_BITS-1:0] rsp_wdat;

  assign bus.req_ready = (req_cnt != REQ_CW'(REQ_DEPTH));
  assign req_push      = bus.req_valid && bus.req_ready;
  assign head_valid    = (req_cnt != '0);
  assign head          = req_mem[req_rp];
  assign head_oor      = ({1'b0, head.addr} >= ADDR_LIMIT);

  // Store accepted requests; storage needs no reset since req_cnt gates it.
  always_ff @(posedge clk) begin
    if (req_push)
      req_mem[req_wp] <= req_t'{we: bus.req_we, addr: bus.req_addr,
                                bwe: bus.req_bwe, wdat: bus.req_wdat};
  end

  // Request FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_wp  <= '0;
      req_rp  <= '0;
      req_cnt <= '0;
    end else begin
      if (req_push) req_wp <= (req_wp == REQ_PW'(REQ_DEPTH - 1)) ? '0 : req_wp + REQ_PW'(1);
      if (req_pop)  req_rp <= (req_rp == REQ_PW'(REQ_DEPTH - 1)) ? '0 : req_rp + REQ_PW'(1);
      case ({req_push, req_pop})
        2'b10:   req_cnt <= req_cnt + REQ_CW'(1);
        2'b01:   req_cnt <= req_cnt - REQ_CW'(1);
        default: ;
      endcase
    end
  end

  // Count reads still travelling through the RAM pipeline.
  always_comb begin
    inflight = '0;
    for (int i = 1; i <= TOTAL_LATENCY; i++)
      inflight = inflight + CRD_W'(vld_pipe[i]);
  end

  // A response popped this cycle frees its slot immediately, so a full FIFO
  // being drained keeps issuing without a bubble.
  assign credit_used = inflight + CRD_W'(rsp_cnt) - CRD_W'(rsp_pop);
  assign credit_ok   = (credit_used < CRD_W'(RSP_DEPTH));
  assign issue       = head_valid && !bus.hw_yield && (head.we || credit_ok);
  assign rd_issue    = issue && !head.we;
  assign req_pop     = issue;

  // Out-of-range entries pop like normal accesses but never touch the RAM.
  assign bus.hw_cs  = issue && !head_oor;
  assign bus.hw_we  = issue && head.we && !head_oor;
  assign bus.hw_add = head_valid ? head.addr : '0;
  assign bus.hw_bwe = !head_valid ? '0 : (head.we ? head.bwe : '1);
  assign bus.hw_din = head_valid ? head.wdat : '0;

  // Shift read tags down the pipeline in step with the RAM latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      oor_pipe <= '0;
    end else begin
      vld_pipe[1] <= rd_issue;
      oor_pipe[1] <= rd_issue && head_oor;
      for (int i = 2; i <= TOTAL_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        oor_pipe[i] <= oor_pipe[i-1];
      end
    end
  end

  assign rsp_push      = vld_pipe[TOTAL_LATENCY];
  assign rsp_wdat      = oor_pipe[TOTAL_LATENCY] ? '0 : bus.hw_dout;
  assign rsp_full      = (rsp_cnt == RSP_CW'(RSP_DEPTH));
  assign rsp_empty     = (rsp_cnt == '0);
  assign bus.rsp_valid = !rsp_empty;
  assign bus.rsp_dat   = rsp_empty ? '0 : rsp_mem[rsp_rp];
  assign rsp_pop       = bus.rsp_valid && bus.rsp_ready;

  // Capture returning read data; at full a same-cycle pop frees the head slot.
  always_ff @(posedge clk) begin
    if (rsp_push) rsp_mem[rsp_wp] <= rsp_wdat;
  end

  // Response FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_wp  <= '0;
      rsp_rp  <= '0;
      rsp_cnt <= '0;
    end else begin
      if (rsp_push) rsp_wp <= (rsp_wp == RSP_PW'(RSP_DEPTH - 1)) ? '0 : rsp_wp + RSP_PW'(1);
      if (rsp_pop)  rsp_rp <= (rsp_rp == RSP_PW'(RSP_DEPTH - 1)) ? '0 : rsp_rp + RSP_PW'(1);
      case ({rsp_push, rsp_pop})
        2'b10:   rsp_cnt <= rsp_cnt + RSP_CW'(1);
        2'b01:   rsp_cnt <= rsp_cnt - RSP_CW'(1);
        default: ;
      endcase
    end
  end

  // Credits must make an overflowing push impossible.
  a_rsp_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(rsp_push && rsp_full && !rsp_pop));

  assign idle = !head_valid && (vld_pipe == '0) && rsp_empty;

  // Sticky out-of-range flag, raised when such a request is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      oor_err <= 1'b0;
    else if (req_push && ({1'b0, bus.req_addr} >= ADDR_LIMIT))
      oor_err <= 1'b1;
  end

  // Saturating count of cycles a waiting head was held off by the wrapper.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      yield_cnt <= '0;
    else if (head_valid && bus.hw_yield && (yield_cnt != 16'hFFFF))
      yield_cnt <= yield_cnt + 16'd1;
  end
endmodule
